csr_access_sequencer: RTL and testbench
=======================================

// Module: csr_access_sequencer
// PURPOSE
//  Sequences all accesses to the machine-mode CSR file. It accepts one request at a time from the
//  execute stage: CSRRW/CSRRS/CSRRC, ECALL or MRET. It also arbitrates pending interrupts (enintr)
//  against those requests. Each request becomes an ordered read / modify / write, trap-entry or
//  trap-return cycle on the CSR file port, and the block returns the old CSR value or a PC redirect.
// PARAMETERS
//  XLEN      32  datapath width; csr_wdata, csr_rdata, req_src, req_pc, irq_pc and rsp_* widths
//  CSR_AW    12  CSR address width
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       synchronous, active-high
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted on the cycle where req_valid & req_ready
//  req_op       in   3       1=CSRRW 2=CSRRS 3=CSRRC 4=ECALL 5=MRET; 0/6/7 illegal
//  req_csr      in   12      CSR address
//  req_src      in   XLEN    rs1 value or zero-extended zimm
//  req_src_zero in   1       rs1/zimm field is x0/0; suppresses the write for CSRRS/CSRRC
//  req_pc       in   XLEN    PC of the requesting instruction
//  enintr       in   1       interrupt pending and enabled, from the CSR file
//  irq_ok       in   1       pipeline is at an instruction boundary; interrupt may be taken
//  irq_pc       in   XLEN    PC to save in mepc when an interrupt is taken
//  csr_addr     out  12      CSR file address
//  csr_wren     out  1       CSR file write enable
//  csr_wdata    out  XLEN    CSR file write data (new value, or mepc on trap entry)
//  csr_rdata    in   XLEN    CSR file combinational read data
//  csr_fault    in   1       CSR file fault (unmapped address)
//  csr_ecall    out  1       ECALL strobe to the CSR file
//  csr_intr     out  1       INTR strobe to the CSR file
//  csr_mret     out  1       MRET strobe to the CSR file
//  rsp_valid    out  1       one-cycle response pulse
//  rsp_rdata    out  XLEN    old CSR value (CSR ops), for writeback to rd
//  rsp_redirect out  1       rsp_pc is the next fetch PC
//  rsp_pc       out  XLEN    trap vector or mepc
//  rsp_fault    out  1       illegal op or CSR fault; no write has been performed
//  busy         out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset: state=IDLE. Every output is 0, including req_ready and all rsp_*/csr_* outputs. A reset
//    mid-operation abandons the operation with no further CSR strobe or write.
//  States: IDLE, READ, WRITE, TRAP, RET, RESP. Only one operation is in flight; there is no queue.
//  IDLE: req_ready = ~(enintr & irq_ok). Priority: interrupt > request.
//    enintr & irq_ok -> latch irq_pc, go to TRAP with kind=INTR.
//    accept op 1-3 -> READ. op 4 -> TRAP with kind=ECALL, latching req_pc. op 5 -> RET.
//    Illegal op -> RESP with rsp_fault=1 and no CSR access.
//    Request fields are latched on acceptance. Inputs are ignored in every state except IDLE.
//  READ (1 cycle): csr_addr=req_csr, csr_wren=0. Latch old=csr_rdata and the fault flag.
//    fault -> RESP with rsp_fault=1.
//    RW -> new=src. RS -> new=old|src. RC -> new=old&~src.
//    RS/RC with src_zero -> RESP without a write. Otherwise -> WRITE.
//  WRITE (1 cycle): csr_addr=req_csr, csr_wren=1, csr_wdata=new.
//    csr_fault seen here -> rsp_fault=1. Then -> RESP.
//  TRAP (1 cycle): csr_wren=1 and csr_wdata = latched pc.
//    csr_ecall=1 for ECALL, csr_intr=1 for INTR; the other strobe stays 0.
//    Latch target=csr_rdata (aligned mtvec). Then -> RESP with redirect.
//  RET (1 cycle): csr_mret=1, csr_wren=0. Latch target=csr_rdata (mepc). Then -> RESP with redirect.
//  RESP (1 cycle): rsp_valid=1, then -> IDLE. The response cannot be back-pressured.
//    rsp_rdata=old for CSR ops, else 0. rsp_pc is valid only while rsp_redirect=1.
//  Outside READ/WRITE csr_addr=0. Outside WRITE/TRAP csr_wren=0, csr_wdata=0.
//    At most one strobe among csr_ecall, csr_intr and csr_mret is high in any cycle.
//  Latency from the acceptance edge to rsp_valid: 3 cycles for a written CSR op;
//    2 cycles for a no-write op, a faulted op, TRAP or RET; 1 cycle for an illegal op.
//    The next acceptance can occur in the cycle after RESP.
//  An interrupt raised while busy is taken only at the next IDLE cycle with irq_ok=1.
//  If enintr and req_valid arrive in the same IDLE cycle, the request waits (req_ready=0).
// TESTING
//  CSRRW csr=0x340 src=0xDEADBEEF, mscratch=0x1234 -> one csr_wren pulse with wdata 0xDEADBEEF;
//    rsp_rdata=0x1234 at acceptance+3.
//  CSRRS csr=0x300 src=0x8, mstatus=0x1800 -> wdata=0x1808. Same op with src_zero=1 ->
//    no csr_wren; rsp at acceptance+2.
//  ECALL req_pc=0x100, mtvec=0x201 -> csr_ecall & csr_wren with wdata=0x100;
//    rsp_redirect=1, rsp_pc=0x200.
//  enintr=1, irq_ok=1, req_valid=1 in the same cycle -> req_ready=0 and csr_intr is taken first;
//    the request is accepted after RESP.
//  CSRRC csr=0x7FF -> rsp_fault=1, no csr_wren. Op 6 -> rsp_fault=1 at acceptance+1.
//  Reset asserted in WRITE -> no csr_wren on the next cycle; all outputs 0; state IDLE.

Source files
------------

// File: rtl/csr_access_sequencer.sv
// Machine-mode CSR access sequencer: orders read/modify/write, trap-entry and trap-return
// cycles on the CSR file port and arbitrates pending interrupts against execute-stage requests.
module csr_access_sequencer #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CSR_AW = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [CSR_AW-1:0] req_csr,
    input  logic [XLEN-1:0]   req_src,
    input  logic              req_src_zero,
    input  logic [XLEN-1:0]   req_pc,
    input  logic              enintr,
    input  logic              irq_ok,
    input  logic [XLEN-1:0]   irq_pc,
    output logic [CSR_AW-1:0] csr_addr,
    output logic              csr_wren,
    output logic [XLEN-1:0]   csr_wdata,
    input  logic [XLEN-1:0]   csr_rdata,
    input  logic              csr_fault,
    output logic              csr_ecall,
    output logic              csr_intr,
    output logic              csr_mret,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_redirect,
    output logic [XLEN-1:0]   rsp_pc,
    output logic              rsp_fault,
    output logic              busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_TRAP  = 3'd3;
    localparam logic [2:0] S_RET   = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [2:0] OP_RW    = 3'd1;
    localparam logic [2:0] OP_RS    = 3'd2;
    localparam logic [2:0] OP_RC    = 3'd3;
    localparam logic [2:0] OP_ECALL = 3'd4;
    localparam logic [2:0] OP_MRET  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [CSR_AW-1:0] csr_q, csr_d;
    logic [XLEN-1:0]   src_q, src_d;
    logic              zero_q, zero_d;
    logic [XLEN-1:0]   old_q, old_d;

    logic              is_intr;
    logic              fault;
    logic [XLEN-1:0]   trap_pc;
    logic [XLEN-1:0]   new_val;
    logic [XLEN-1:0]   target;

    logic [CSR_AW-1:0] csr_addr_d;
    logic              csr_wren_d, csr_ecall_d, csr_intr_d, csr_mret_d;
    logic [XLEN-1:0]   csr_wdata_d, rsp_rdata_d, rsp_pc_d;
    logic              rsp_valid_d, rsp_redirect_d, rsp_fault_d, busy_d;

    // Interrupts win over requests; the request simply waits with ready low.
    assign req_ready = (state_q == S_IDLE) && !reset && !(enintr && irq_ok);

    // Next state and next registered outputs, derived from the state being entered.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        csr_d   = csr_q;
        src_d   = src_q;
        zero_d  = zero_q;
        old_d   = old_q;
        is_intr = 1'b0;
        fault   = 1'b0;
        trap_pc = '0;
        new_val = '0;
        target  = '0;

        case (state_q)
            S_IDLE: begin
                if (enintr && irq_ok) begin
                    is_intr = 1'b1;
                    trap_pc = irq_pc;
                    old_d   = '0;
                    state_d = S_TRAP;
                end else if (req_valid) begin
                    op_d   = req_op;
                    csr_d  = req_csr;
                    src_d  = req_src;
                    zero_d = req_src_zero;
                    old_d  = '0;
                    case (req_op)
                        OP_RW, OP_RS, OP_RC: state_d = S_READ;
                        OP_ECALL: begin
                            trap_pc = req_pc;
                            state_d = S_TRAP;
                        end
                        OP_MRET: state_d = S_RET;
                        default: begin
                            fault   = 1'b1;
                            state_d = S_RESP;
                        end
                    endcase
                end
            end
            S_READ: begin
                old_d = csr_rdata;
                case (op_q)
                    OP_RS:   new_val = csr_rdata | src_q;
                    OP_RC:   new_val = csr_rdata & ~src_q;
                    default: new_val = src_q;
                endcase
                if (csr_fault) begin
                    fault   = 1'b1;
                    state_d = S_RESP;
                end else if ((op_q != OP_RW) && zero_q) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                fault   = csr_fault;
                state_d = S_RESP;
            end
            S_TRAP, S_RET: begin
                target  = csr_rdata;
                state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase

        csr_addr_d     = ((state_d == S_READ) || (state_d == S_WRITE)) ? csr_d : '0;
        csr_wren_d     = (state_d == S_WRITE) || (state_d == S_TRAP);
        csr_wdata_d    = (state_d == S_WRITE) ? new_val :
                         (state_d == S_TRAP)  ? trap_pc : '0;
        csr_ecall_d    = (state_d == S_TRAP) && !is_intr;
        csr_intr_d     = (state_d == S_TRAP) && is_intr;
        csr_mret_d     = (state_d == S_RET);
        rsp_valid_d    = (state_d == S_RESP);
        rsp_rdata_d    = rsp_valid_d ? old_d : '0;
        rsp_redirect_d = rsp_valid_d && ((state_q == S_TRAP) || (state_q == S_RET));
        rsp_pc_d       = rsp_redirect_d ? target : '0;
        rsp_fault_d    = rsp_valid_d && fault;
        busy_d         = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            csr_q        <= '0;
            src_q        <= '0;
            zero_q       <= 1'b0;
            old_q        <= '0;
            csr_addr     <= '0;
            csr_wren     <= 1'b0;
            csr_wdata    <= '0;
            csr_ecall    <= 1'b0;
            csr_intr     <= 1'b0;
            csr_mret     <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_redirect <= 1'b0;
            rsp_pc       <= '0;
            rsp_fault    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            csr_q        <= csr_d;
            src_q        <= src_d;
            zero_q       <= zero_d;
            old_q        <= old_d;
            csr_addr     <= csr_addr_d;
            csr_wren     <= csr_wren_d;
            csr_wdata    <= csr_wdata_d;
            csr_ecall    <= csr_ecall_d;
            csr_intr     <= csr_intr_d;
            csr_mret     <= csr_mret_d;
            rsp_valid    <= rsp_valid_d;
            rsp_rdata    <= rsp_rdata_d;
            rsp_redirect <= rsp_redirect_d;
            rsp_pc       <= rsp_pc_d;
            rsp_fault    <= rsp_fault_d;
            busy         <= busy_d;
        end
    end
endmodule

// File: tb/tb_csr_access_sequencer.sv
// Bench for csr_access_sequencer: a CSR file environment, a transaction-level model that expands
// each accepted request into its expected per-cycle port activity, and directed plus random stimulus.
module tb_csr_access_sequencer;
    localparam logic [11:0] MTVEC = 12'h305;
    localparam logic [11:0] MEPC  = 12'h341;

    logic        clk, reset;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_csr;
    logic [31:0] req_src, req_pc, irq_pc;
    logic        req_src_zero, enintr, irq_ok;
    logic [11:0] csr_addr;
    logic        csr_wren, csr_fault, csr_ecall, csr_intr, csr_mret;
    logic [31:0] csr_wdata, csr_rdata;
    logic        rsp_valid, rsp_redirect, rsp_fault, busy;
    logic [31:0] rsp_rdata, rsp_pc;

    int n_checks = 0;
    int n_errors = 0;

    csr_access_sequencer #(.XLEN(32), .CSR_AW(12)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_csr(req_csr),
        .req_src(req_src), .req_src_zero(req_src_zero), .req_pc(req_pc),
        .enintr(enintr), .irq_ok(irq_ok), .irq_pc(irq_pc),
        .csr_addr(csr_addr), .csr_wren(csr_wren), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_fault(csr_fault),
        .csr_ecall(csr_ecall), .csr_intr(csr_intr), .csr_mret(csr_mret),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_redirect(rsp_redirect),
        .rsp_pc(rsp_pc), .rsp_fault(rsp_fault), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file environment: low byte 0xFF is unmapped, 0xCxx-0xFxx is read-only.
    logic [31:0] mem [4096];

    function automatic logic unmapped(input logic [11:0] a);
        return a[7:0] == 8'hFF;
    endfunction

    function automatic logic rdonly(input logic [11:0] a);
        return a[11:10] == 2'b11;
    endfunction

    assign csr_rdata = (csr_ecall || csr_intr) ? {mem[MTVEC][31:2], 2'b00} :
                       csr_mret ? mem[MEPC] : mem[csr_addr];
    assign csr_fault = unmapped(csr_addr) || (csr_wren && rdonly(csr_addr));

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
        end else if (csr_ecall || csr_intr) begin
            mem[MEPC] <= csr_wdata;
        end else if (csr_wren && !csr_fault) begin
            mem[csr_addr] <= csr_wdata;
        end
    end

    typedef struct packed {
        logic [11:0] addr;
        logic        wren;
        logic [31:0] wdata;
        logic        ecall;
        logic        intr;
        logic        mret;
        logic        rvalid;
        logic [31:0] rdata;
        logic        redirect;
        logic [31:0] pc;
        logic        fault;
        logic        busy;
        logic        ready;
    } obs_t;

    obs_t expq[$];

    task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.addr = csr_addr;   o.wren = csr_wren;   o.wdata = csr_wdata;
        o.ecall = csr_ecall; o.intr = csr_intr;   o.mret = csr_mret;
        o.rvalid = rsp_valid; o.rdata = rsp_rdata; o.redirect = rsp_redirect;
        o.pc = rsp_redirect ? rsp_pc : 32'h0;
        o.fault = rsp_fault; o.busy = busy;       o.ready = req_ready;
        return o;
    endfunction

    function automatic obs_t resp(input logic [31:0] rd, input logic redir, input logic [31:0] pc,
                                  input logic flt);
        obs_t c = '0;
        c.rvalid = 1'b1; c.rdata = rd; c.redirect = redir; c.pc = pc; c.fault = flt; c.busy = 1'b1;
        return c;
    endfunction

    // Expand one accepted transaction into the cycles that follow its acceptance.
    task automatic predict(input logic is_irq, input logic [2:0] op, input logic [11:0] a,
                           input logic [31:0] src, input logic zero, input logic [31:0] pc);
        obs_t c;
        logic [31:0] old, nv, vec;
        old = mem[a];
        vec = {mem[MTVEC][31:2], 2'b00};
        c = '0;
        c.busy = 1'b1;
        if (is_irq || op == 3'd4) begin
            c.wren = 1'b1; c.wdata = pc; c.intr = is_irq; c.ecall = !is_irq;
            expq.push_back(c);
            expq.push_back(resp(32'h0, 1'b1, vec, 1'b0));
        end else if (op == 3'd5) begin
            c.mret = 1'b1;
            expq.push_back(c);
            expq.push_back(resp(32'h0, 1'b1, mem[MEPC], 1'b0));
        end else if (op >= 3'd1 && op <= 3'd3) begin
            c.addr = a;
            expq.push_back(c);
            nv = (op == 3'd1) ? src : (op == 3'd2) ? (old | src) : (old & ~src);
            if (unmapped(a)) begin
                expq.push_back(resp(old, 1'b0, 32'h0, 1'b1));
            end else if (op != 3'd1 && zero) begin
                expq.push_back(resp(old, 1'b0, 32'h0, 1'b0));
            end else begin
                c.wren = 1'b1; c.wdata = nv;
                expq.push_back(c);
                expq.push_back(resp(old, 1'b0, 32'h0, rdonly(a)));
            end
        end else begin
            expq.push_back(resp(32'h0, 1'b0, 32'h0, 1'b1));
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        obs_t e;
        e = '0;
        if (reset) begin
            expq.delete();
        end else if (expq.size() == 0) begin
            e.ready = !(enintr && irq_ok);
            if (enintr && irq_ok)
                predict(1'b1, 3'd0, 12'h0, 32'h0, 1'b0, irq_pc);
            else if (req_valid)
                predict(1'b0, req_op, req_csr, req_src, req_src_zero, req_pc);
        end else begin
            e = expq.pop_front();
        end
        chk_obs("cycle", sample(), e);
    end

    task automatic do_req(input logic [2:0] op, input logic [11:0] a, input logic [31:0] src,
                          input logic zero, input logic [31:0] pc, output int lat);
        int k;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_csr = a; req_src = src;
        req_src_zero = zero; req_pc = pc;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk_val("accept_timeout", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 10);
    endtask

    logic [11:0] csr_tab [8];
    int lat;
    int r;

    initial begin
        csr_tab[0] = 12'h340; csr_tab[1] = 12'h300; csr_tab[2] = 12'h305; csr_tab[3] = 12'h341;
        csr_tab[4] = 12'h344; csr_tab[5] = 12'h7FF; csr_tab[6] = 12'hF11; csr_tab[7] = 12'h3FF;
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_csr = '0; req_src = '0;
        req_src_zero = 1'b0; req_pc = '0; enintr = 1'b0; irq_ok = 1'b0; irq_pc = '0;
        repeat (2) @(negedge clk);
        chk_obs("reset_state", sample(), '0);
        @(posedge clk); #1;
        reset = 1'b0;

        do_req(3'd1, 12'h340, 32'h0000_1234, 1'b0, 32'h0, lat);
        do_req(3'd1, 12'h340, 32'hDEAD_BEEF, 1'b0, 32'h0, lat);
        chk_val("csrrw_latency", 32'(lat), 32'd3);
        chk_val("csrrw_rdata", rsp_rdata, 32'h0000_1234);
        chk_val("csrrw_written", mem[12'h340], 32'hDEAD_BEEF);

        do_req(3'd1, 12'h300, 32'h0000_1800, 1'b0, 32'h0, lat);
        do_req(3'd2, 12'h300, 32'h0000_0008, 1'b0, 32'h0, lat);
        chk_val("csrrs_latency", 32'(lat), 32'd3);
        chk_val("csrrs_written", mem[12'h300], 32'h0000_1808);
        do_req(3'd2, 12'h300, 32'h0000_0000, 1'b1, 32'h0, lat);
        chk_val("csrrs_zero_latency", 32'(lat), 32'd2);
        chk_val("csrrs_zero_rdata", rsp_rdata, 32'h0000_1808);

        do_req(3'd1, 12'h305, 32'h0000_0201, 1'b0, 32'h0, lat);
        do_req(3'd4, 12'h000, 32'h0, 1'b0, 32'h0000_0100, lat);
        chk_val("ecall_latency", 32'(lat), 32'd2);
        chk_val("ecall_redirect", 32'(rsp_redirect), 32'h1);
        chk_val("ecall_pc", rsp_pc, 32'h0000_0200);
        chk_val("ecall_mepc", mem[MEPC], 32'h0000_0100);

        do_req(3'd5, 12'h000, 32'h0, 1'b0, 32'h0, lat);
        chk_val("mret_latency", 32'(lat), 32'd2);
        chk_val("mret_pc", rsp_pc, 32'h0000_0100);

        do_req(3'd3, 12'h7FF, 32'h0000_0001, 1'b0, 32'h0, lat);
        chk_val("unmapped_latency", 32'(lat), 32'd2);
        chk_val("unmapped_fault", 32'(rsp_fault), 32'h1);
        do_req(3'd1, 12'hF11, 32'h0000_0055, 1'b0, 32'h0, lat);
        chk_val("readonly_fault", 32'(rsp_fault), 32'h1);
        do_req(3'd6, 12'h340, 32'h0, 1'b0, 32'h0, lat);
        chk_val("illegal_latency", 32'(lat), 32'd1);
        chk_val("illegal_fault", 32'(rsp_fault), 32'h1);

        // Interrupt and request collide: interrupt first, request after the trap response.
        @(posedge clk); #1;
        enintr = 1'b1; irq_ok = 1'b1; irq_pc = 32'h0000_0400;
        req_valid = 1'b1; req_op = 3'd1; req_csr = 12'h340; req_src = 32'h5; req_src_zero = 1'b0;
        @(negedge clk);
        chk_val("irq_blocks_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        enintr = 1'b0;
        @(negedge clk);
        chk_val("irq_strobe", 32'(csr_intr), 32'h1);
        chk_val("irq_wdata", csr_wdata, 32'h0000_0400);
        r = 0;
        while (!req_ready && r < 10) begin
            @(negedge clk);
            r++;
        end
        chk_val("irq_then_accept", 32'(r), 32'd2);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("post_irq_rdata", rsp_rdata, 32'hDEAD_BEEF);

        // Reset while in WRITE abandons the write.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'd1; req_csr = 12'h344; req_src = 32'h55;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_val("write_cycle_wren", 32'(csr_wren), 32'h1);
        #2 reset = 1'b1;
        @(negedge clk);
        chk_obs("reset_in_write", sample(), '0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Random phase: the per-cycle compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            r = int'($urandom % 16);
            req_valid = ($urandom % 4) != 0;
            if (r < 10)       req_op = 3'(1 + r % 3);
            else if (r < 12)  req_op = 3'd4;
            else if (r < 14)  req_op = 3'd5;
            else if (r == 14) req_op = 3'd0;
            else              req_op = 3'(6 + ($urandom % 2));
            req_csr = csr_tab[$urandom_range(0, 7)];
            req_src = ($urandom % 2) ? $urandom : 32'($urandom % 16);
            req_src_zero = ($urandom % 4) == 0;
            req_pc = $urandom & 32'hFFFF_FFFC;
            enintr = ($urandom % 8) == 0;
            irq_ok = ($urandom % 2) == 0;
            irq_pc = $urandom & 32'hFFFF_FFFC;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; enintr = 1'b0;
        repeat (10) @(negedge clk);
        chk_val("drained", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
